memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning max cycles awaiting mem_ack before abort (range 1..15).
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  in  1  execute stage presents an instruction.
REQ-005 SHALL have ports mem_rd_en, mem_wr_en  in  1 each  load / store request.
REQ-006 SHALL have ports alu_result, store_data, pc_plus2  in  16 each  address/result, store value, PC+2.
REQ-007 SHALL have ports branch, reg_write_src, reg_write_en  in  1 each; branch_cond, flags  in  3 each; rd  in  4  (all passed through).
REQ-008 SHALL have port flush  in  1  kill the instruction currently held in this stage.
REQ-009 SHALL have ports dmem_req, dmem_we  out  1 each; dmem_addr, dmem_wdata  out  16 each; dmem_ack  in  1; dmem_rdata  in  16.
REQ-010 SHALL have port stall  out  1  execute must hold its outputs.
REQ-011 SHALL have ports wb_valid, wb_branch, wb_reg_write_src, wb_reg_write_en  out  1 each; wb_branch_cond, wb_flags  out  3 each; wb_rd  out  4; wb_pc_plus2, wb_alu_result, wb_mem_read  out  16 each.
REQ-012 SHALL have port mem_err  out  1  one-cycle pulse on misalignment or timeout.

Function
REQ-013 SHALL implement FSM states IDLE and WAIT_ACK.
REQ-014 Non-memory op (in_valid, neither enable) in IDLE SHALL register all pass-through fields into wb_* on the next edge with wb_valid=1, wb_mem_read=0; latency 1 cycle.
REQ-015 Memory op in IDLE with alu_result[0]=0 SHALL assert dmem_req combinationally that cycle (dmem_we=mem_wr_en, dmem_addr=alu_result, dmem_wdata=store_data), latch the instruction, and go to WAIT_ACK unless dmem_ack is already high.
REQ-016 dmem_req, dmem_we, dmem_addr, dmem_wdata SHALL stay stable from first assertion until the cycle dmem_ack=1.
REQ-017 stall SHALL be 1 in every cycle a memory op is outstanding without dmem_ack, and 0 otherwise.
REQ-018 On dmem_ack, SHALL register wb_mem_read=dmem_rdata for loads (0 for stores), set wb_valid=1 next cycle, return to IDLE; same-cycle ack gives 1-cycle latency.
REQ-019 Timeout counter (4 bits) SHALL clear on request issue and increment each WAIT_ACK cycle; at count==TIMEOUT without ack, SHALL drop dmem_req, pulse mem_err, emit instruction with wb_mem_read=16'h0000, wb_reg_write_en=0, return to IDLE.
REQ-020 Misaligned memory op (alu_result[0]=1) SHALL issue no request, pulse mem_err, emit wb_valid=1 with wb_reg_write_en=0, no stall.
REQ-021 flush in IDLE SHALL yield wb_valid=0 next cycle; flush in WAIT_ACK SHALL hold dmem_req until ack (stores complete) then emit wb_valid=0.
REQ-022 in_valid=0 in IDLE SHALL yield wb_valid=0 next cycle; wb_* data fields hold previous values.
REQ-023 dmem_ack while not requesting SHALL be ignored.

Reset
REQ-024 rst_n=0 SHALL asynchronously force state IDLE, counter 0, all wb_* outputs 0, mem_err 0; dmem_req and stall SHALL read 0 while in reset.
REQ-025 Reset mid-WAIT_ACK SHALL abandon the request with no wb_valid and no mem_err.

Structure
REQ-026 FSM state encoding and TIMEOUT default SHALL live in shared package cpu_pkg.
REQ-027 Timeout counter SHALL be sub-module mem_timeout_counter (clear, enable, expired).

Verification
REQ-028 ADD, alu_result=16'h1234, rd=3 -> next cycle wb_valid=1, wb_alu_result=16'h1234, wb_rd=3, stall never high.
REQ-029 Load addr 16'h0040, ack after 3 cycles with rdata 16'hBEEF -> stall high 3 cycles, address stable, wb_mem_read=16'hBEEF one cycle after ack.
REQ-030 Store addr 16'h0010, data 16'hA5A5, same-cycle ack -> dmem_we=1 one cycle, no stall, wb_valid=1 next cycle, wb_mem_read=0.
REQ-031 Load, no ack -> mem_err pulses at 15th WAIT_ACK cycle, dmem_req drops, wb_reg_write_en=0.
REQ-032 Load addr 16'h0041 -> no dmem_req, mem_err pulse, wb_reg_write_en=0; separately rst_n low in WAIT_ACK -> all outputs 0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-stage FSM encoding, timeout default and the
// bundle of fields that travel from execute to writeback.
package cpu_pkg;

    localparam int TIMEOUT_DEFAULT = 15;
    localparam int CNT_W           = 4;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } mem_state_e;

    // Field order matters only for packing; keep it stable.
    typedef struct packed {
        logic        branch;
        logic        reg_write_src;
        logic        reg_write_en;
        logic [2:0]  branch_cond;
        logic [2:0]  flags;
        logic [3:0]  rd;
        logic [15:0] pc_plus2;
        logic [15:0] alu_result;
    } wb_fields_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles spent waiting for a data-memory acknowledge and flags the
// cycle in which the wait reaches the TIMEOUT limit.
module mem_timeout_counter
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_inc;

    // Next count and expiry: expiry fires when this wait cycle brings the count to LIMIT.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        count_inc = count_q + CNT_W'(1);
        count_d   = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_inc;
        end
        expired = enable && !clear && (count_inc == LIMIT);
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: passes ALU ops through, issues aligned loads/stores to
// data memory, stalls execute while waiting, and aborts on misalignment or
// acknowledge timeout.
module memory_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        mem_rd_en,
    input  logic        mem_wr_en,
    input  logic [15:0] alu_result,
    input  logic [15:0] store_data,
    input  logic [15:0] pc_plus2,
    input  logic        branch,
    input  logic        reg_write_src,
    input  logic        reg_write_en,
    input  logic [2:0]  branch_cond,
    input  logic [2:0]  flags,
    input  logic [3:0]  rd,
    input  logic        flush,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_branch,
    output logic        wb_reg_write_src,
    output logic        wb_reg_write_en,
    output logic [2:0]  wb_branch_cond,
    output logic [2:0]  wb_flags,
    output logic [3:0]  wb_rd,
    output logic [15:0] wb_pc_plus2,
    output logic [15:0] wb_alu_result,
    output logic [15:0] wb_mem_read,
    output logic        mem_err
);

    mem_state_e  state_q, state_d;
    wb_fields_t  in_fields;
    wb_fields_t  hold_q, hold_d;          // instruction parked while waiting
    logic        hold_rd_q, hold_rd_d;    // parked op is a load
    logic        req_we_q, req_we_d;
    logic [15:0] req_wdata_q, req_wdata_d;
    logic        flushed_q, flushed_d;    // parked op was killed; finish bus cycle silently
    wb_fields_t  wb_q, wb_d;
    logic        wb_valid_q, wb_valid_d;
    logic [15:0] wb_mem_read_q, wb_mem_read_d;
    logic        mem_err_q, mem_err_d;

    logic        cnt_clear;
    logic        cnt_enable;
    logic        cnt_expired;
    logic        mem_op;
    logic        kill;

    assign in_fields = '{branch:        branch,
                         reg_write_src: reg_write_src,
                         reg_write_en:  reg_write_en,
                         branch_cond:   branch_cond,
                         flags:         flags,
                         rd:            rd,
                         pc_plus2:      pc_plus2,
                         alu_result:    alu_result};

    assign mem_op = mem_rd_en || mem_wr_en;
    assign kill   = flushed_q || flush;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (cnt_expired)
    );

    // Next-state, bus request and writeback decode for both FSM states.
    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        hold_rd_d     = hold_rd_q;
        req_we_d      = req_we_q;
        req_wdata_d   = req_wdata_q;
        flushed_d     = flushed_q;
        wb_d          = wb_q;
        wb_valid_d    = 1'b0;
        wb_mem_read_d = wb_mem_read_q;
        mem_err_d     = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        dmem_addr     = '0;
        dmem_wdata    = '0;
        stall         = 1'b0;
        cnt_clear     = 1'b0;
        cnt_enable    = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    if (mem_op && !alu_result[0]) begin
                        dmem_req    = 1'b1;
                        dmem_we     = mem_wr_en;
                        dmem_addr   = alu_result;
                        dmem_wdata  = store_data;
                        cnt_clear   = 1'b1;
                        hold_d      = in_fields;
                        hold_rd_d   = mem_rd_en;
                        req_we_d    = mem_wr_en;
                        req_wdata_d = store_data;
                        flushed_d   = 1'b0;
                        if (dmem_ack) begin
                            wb_d          = in_fields;
                            wb_mem_read_d = mem_rd_en ? dmem_rdata : 16'h0000;
                            wb_valid_d    = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            state_d = WAIT_ACK;
                        end
                    end else if (mem_op) begin
                        wb_d              = in_fields;
                        wb_d.reg_write_en = 1'b0;
                        wb_mem_read_d     = 16'h0000;
                        wb_valid_d        = 1'b1;
                        mem_err_d         = 1'b1;
                    end else begin
                        wb_d          = in_fields;
                        wb_mem_read_d = 16'h0000;
                        wb_valid_d    = 1'b1;
                    end
                end
            end
            WAIT_ACK: begin
                dmem_req   = 1'b1;
                dmem_we    = req_we_q;
                dmem_addr  = hold_q.alu_result;
                dmem_wdata = req_wdata_q;
                cnt_enable = !dmem_ack;
                if (dmem_ack) begin
                    state_d = IDLE;
                    if (!kill) begin
                        wb_d          = hold_q;
                        wb_mem_read_d = hold_rd_q ? dmem_rdata : 16'h0000;
                        wb_valid_d    = 1'b1;
                    end
                end else if (cnt_expired) begin
                    stall     = 1'b1;
                    state_d   = IDLE;
                    mem_err_d = 1'b1;
                    if (!kill) begin
                        wb_d              = hold_q;
                        wb_d.reg_write_en = 1'b0;
                        wb_mem_read_d     = 16'h0000;
                        wb_valid_d        = 1'b1;
                    end
                end else begin
                    stall     = 1'b1;
                    flushed_d = kill;
                end
            end
            default: state_d = IDLE;
        endcase

        // Inputs may still toggle during reset; keep the bus and stall quiet.
        if (!rst_n) begin
            dmem_req   = 1'b0;
            dmem_we    = 1'b0;
            dmem_addr  = '0;
            dmem_wdata = '0;
            stall      = 1'b0;
        end
    end

    // FSM state, parked instruction and registered writeback outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the parked-instruction registers are reset too; they are few and it keeps post-reset bus outputs defined.
        if (!rst_n) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            hold_rd_q     <= 1'b0;
            req_we_q      <= 1'b0;
            req_wdata_q   <= '0;
            flushed_q     <= 1'b0;
            wb_q          <= '0;
            wb_valid_q    <= 1'b0;
            wb_mem_read_q <= '0;
            mem_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            hold_rd_q     <= hold_rd_d;
            req_we_q      <= req_we_d;
            req_wdata_q   <= req_wdata_d;
            flushed_q     <= flushed_d;
            wb_q          <= wb_d;
            wb_valid_q    <= wb_valid_d;
            wb_mem_read_q <= wb_mem_read_d;
            mem_err_q     <= mem_err_d;
        end
    end

    assign wb_valid         = wb_valid_q;
    assign wb_branch        = wb_q.branch;
    assign wb_reg_write_src = wb_q.reg_write_src;
    assign wb_reg_write_en  = wb_q.reg_write_en;
    assign wb_branch_cond   = wb_q.branch_cond;
    assign wb_flags         = wb_q.flags;
    assign wb_rd            = wb_q.rd;
    assign wb_pc_plus2      = wb_q.pc_plus2;
    assign wb_alu_result    = wb_q.alu_result;
    assign wb_mem_read      = wb_mem_read_q;
    assign mem_err          = mem_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: inputs change on the falling edge,
// combinational outputs are checked 1 ns later, registered outputs one
// falling edge after the rising edge that captured them.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, mem_rd_en, mem_wr_en;
    logic [15:0] alu_result, store_data, pc_plus2;
    logic        branch, reg_write_src, reg_write_en;
    logic [2:0]  branch_cond, flags;
    logic [3:0]  rd;
    logic        flush;
    logic        dmem_req, dmem_we;
    logic [15:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic        stall;
    logic        wb_valid, wb_branch, wb_reg_write_src, wb_reg_write_en;
    logic [2:0]  wb_branch_cond, wb_flags;
    logic [3:0]  wb_rd;
    logic [15:0] wb_pc_plus2, wb_alu_result, wb_mem_read;
    logic        mem_err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    memory_stage #(.TIMEOUT(15)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .mem_rd_en        (mem_rd_en),
        .mem_wr_en        (mem_wr_en),
        .alu_result       (alu_result),
        .store_data       (store_data),
        .pc_plus2         (pc_plus2),
        .branch           (branch),
        .reg_write_src    (reg_write_src),
        .reg_write_en     (reg_write_en),
        .branch_cond      (branch_cond),
        .flags            (flags),
        .rd               (rd),
        .flush            (flush),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata),
        .stall            (stall),
        .wb_valid         (wb_valid),
        .wb_branch        (wb_branch),
        .wb_reg_write_src (wb_reg_write_src),
        .wb_reg_write_en  (wb_reg_write_en),
        .wb_branch_cond   (wb_branch_cond),
        .wb_flags         (wb_flags),
        .wb_rd            (wb_rd),
        .wb_pc_plus2      (wb_pc_plus2),
        .wb_alu_result    (wb_alu_result),
        .wb_mem_read      (wb_mem_read),
        .mem_err          (mem_err)
    );

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 0; mem_rd_en = 0; mem_wr_en = 0; flush = 0;
        alu_result = 0; store_data = 0; pc_plus2 = 0;
        branch = 0; reg_write_src = 0; reg_write_en = 0;
        branch_cond = 0; flags = 0; rd = 0;
        dmem_ack = 0; dmem_rdata = 0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;

        // Reset with a load presented: bus and stall stay quiet.
        #2;
        in_valid = 1; mem_rd_en = 1; alu_result = 16'h0040;
        #1;
        check("rst_req",   dmem_req, 0);
        check("rst_stall", stall, 0);
        check("rst_wbv",   wb_valid, 0);
        check("rst_err",   mem_err, 0);
        check("rst_alu",   wb_alu_result, 0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("post_rst_wbv", wb_valid, 0);

        // ADD: pass-through with 1-cycle latency.
        in_valid = 1; alu_result = 16'h1234; rd = 4'd3; reg_write_en = 1;
        reg_write_src = 1; flags = 3'b101; branch_cond = 3'b010; pc_plus2 = 16'h0102;
        #1;
        check("add_stall", stall, 0);
        check("add_req",   dmem_req, 0);
        @(negedge clk);
        idle_inputs();
        check("add_wbv",   wb_valid, 1);
        check("add_alu",   wb_alu_result, 16'h1234);
        check("add_rd",    wb_rd, 3);
        check("add_flags", wb_flags, 3'b101);
        check("add_bc",    wb_branch_cond, 3'b010);
        check("add_pc",    wb_pc_plus2, 16'h0102);
        check("add_ctl",   {wb_branch, wb_reg_write_src, wb_reg_write_en}, 3'b011);
        check("add_mrd",   wb_mem_read, 0);
        check("add_stall2", stall, 0);
        @(negedge clk);
        check("bubble_wbv", wb_valid, 0);
        check("bubble_hold", wb_alu_result, 16'h1234);

        // Load at 0x0040, ack arrives 3 cycles after issue with 0xBEEF.
        in_valid = 1; mem_rd_en = 1; alu_result = 16'h0040; rd = 4'd5; reg_write_en = 1;
        #1;
        check("ld_req0",  {dmem_req, dmem_we, stall}, 3'b101);
        check("ld_addr0", dmem_addr, 16'h0040);
        @(negedge clk);
        alu_result = 16'h9999;  // ignored while the load is parked
        #1;
        check("ld_req1",  {dmem_req, dmem_we, stall}, 3'b101);
        check("ld_addr1", dmem_addr, 16'h0040);
        check("ld_wbv1",  wb_valid, 0);
        @(negedge clk);
        #1;
        check("ld_req2",  {dmem_req, stall}, 2'b11);
        check("ld_addr2", dmem_addr, 16'h0040);
        @(negedge clk);
        dmem_ack = 1; dmem_rdata = 16'hBEEF;
        #1;
        check("ld_ack_stall", {dmem_req, stall}, 2'b10);
        check("ld_addr3", dmem_addr, 16'h0040);
        @(negedge clk);
        idle_inputs();
        #1;
        check("ld_wbv",  wb_valid, 1);
        check("ld_mrd",  wb_mem_read, 16'hBEEF);
        check("ld_rd",   wb_rd, 5);
        check("ld_alu",  wb_alu_result, 16'h0040);
        check("ld_done", {dmem_req, stall, mem_err}, 3'b000);

        // Store with same-cycle ack.
        @(negedge clk);
        in_valid = 1; mem_wr_en = 1; alu_result = 16'h0010; store_data = 16'hA5A5;
        dmem_ack = 1; dmem_rdata = 16'h1111;
        #1;
        check("st_req",   {dmem_req, dmem_we, stall}, 3'b110);
        check("st_addr",  dmem_addr, 16'h0010);
        check("st_wdata", dmem_wdata, 16'hA5A5);
        @(negedge clk);
        idle_inputs();
        #1;
        check("st_wbv",  wb_valid, 1);
        check("st_mrd",  wb_mem_read, 0);
        check("st_we1",  {dmem_req, dmem_we}, 2'b00);

        // Stray ack in IDLE with nothing outstanding.
        dmem_ack = 1; dmem_rdata = 16'h7777;
        @(negedge clk);
        idle_inputs();
        check("stray_wbv", wb_valid, 0);
        check("stray_mrd", wb_mem_read, 0);

        // Load with no ack: 16 stalled cycles (issue + 15 waits), then abort.
        in_valid = 1; mem_rd_en = 1; alu_result = 16'h0080; rd = 4'd7; reg_write_en = 1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check($sformatf("to_wait%0d", i), {dmem_req, stall, mem_err, wb_valid}, 4'b1100);
            @(negedge clk);
        end
        idle_inputs();
        #1;
        check("to_err",  mem_err, 1);
        check("to_bus",  {dmem_req, stall}, 2'b00);
        check("to_wbv",  wb_valid, 1);
        check("to_rwe",  wb_reg_write_en, 0);
        check("to_mrd",  wb_mem_read, 0);
        check("to_rd",   wb_rd, 7);
        @(negedge clk);
        check("to_pulse", mem_err, 0);

        // Misaligned load at 0x0041.
        in_valid = 1; mem_rd_en = 1; alu_result = 16'h0041; rd = 4'd9; reg_write_en = 1;
        #1;
        check("mis_req", {dmem_req, stall}, 2'b00);
        @(negedge clk);
        idle_inputs();
        check("mis_err", mem_err, 1);
        check("mis_wbv", wb_valid, 1);
        check("mis_rwe", wb_reg_write_en, 0);
        check("mis_rd",  wb_rd, 9);
        @(negedge clk);
        check("mis_pulse", mem_err, 0);

        // Flush in IDLE kills the instruction.
        in_valid = 1; alu_result = 16'h5555; reg_write_en = 1; flush = 1;
        @(negedge clk);
        idle_inputs();
        check("fl_idle_wbv",  wb_valid, 0);
        check("fl_idle_hold", wb_alu_result, 16'h0041);

        // Flush while a store waits: the store still completes, nothing retires.
        in_valid = 1; mem_wr_en = 1; alu_result = 16'h0020; store_data = 16'h1357;
        @(negedge clk);
        flush = 1;
        #1;
        check("fl_wait_req", {dmem_req, dmem_we, stall}, 3'b111);
        @(negedge clk);
        flush = 0; dmem_ack = 1;
        #1;
        check("fl_ack_req", {dmem_req, dmem_we, stall}, 3'b110);
        check("fl_wdata",   dmem_wdata, 16'h1357);
        @(negedge clk);
        idle_inputs();
        check("fl_wbv", {wb_valid, mem_err}, 2'b00);

        // Reset while a load waits: everything clears at once.
        @(negedge clk);
        in_valid = 1; mem_rd_en = 1; alu_result = 16'h0060;
        @(negedge clk);
        #1;
        check("rw_stall", stall, 1);
        rst_n = 0;
        #1;
        check("rw_bus",  {dmem_req, dmem_we, stall}, 3'b000);
        check("rw_addr", dmem_addr, 0);
        check("rw_wb",   {wb_valid, mem_err, wb_reg_write_en}, 3'b000);
        check("rw_alu",  wb_alu_result, 0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        @(negedge clk);
        check("rw_after", {wb_valid, mem_err, dmem_req, stall}, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
